// File: rtl/foxtrot_pkg.sv
// Shared reorder-buffer types: entry layout and depth derived from the id width.
package foxtrot_pkg;

    localparam int ROB_MAX_OPERANDS = 3;
    localparam int ROB_PRN_BITS     = 6;
    localparam int ROB_ARN_BITS     = 6;
    localparam int ROB_INST_ID_BITS = 6;
    localparam int ROB_FU_COUNT     = 4;
    localparam int DEPTH            = 2 ** ROB_INST_ID_BITS;

    typedef struct packed {
        logic                                             valid;
        logic                                             done;
        logic [ROB_MAX_OPERANDS-1:0]                      old_valid;
        logic [ROB_MAX_OPERANDS-1:0][ROB_PRN_BITS-1:0]    old_prn;
        logic [ROB_MAX_OPERANDS-1:0][ROB_ARN_BITS-1:0]    old_arn;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks completions, retires one
// finished head entry per cycle and returns its overwritten PRNs to the free list.
module reorder_buffer
    import foxtrot_pkg::*;
#(
    parameter int MAX_OPERANDS = ROB_MAX_OPERANDS,
    parameter int PRN_BITS     = ROB_PRN_BITS,
    parameter int ARN_BITS     = ROB_ARN_BITS,
    parameter int INST_ID_BITS = ROB_INST_ID_BITS,
    parameter int FU_COUNT     = ROB_FU_COUNT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid,
    input  logic                    alloc_old_valid  [MAX_OPERANDS],
    input  logic [PRN_BITS-1:0]     alloc_old_prn    [MAX_OPERANDS],
    input  logic [ARN_BITS-1:0]     alloc_old_arn    [MAX_OPERANDS],
    input  logic                    complete_valid   [FU_COUNT],
    input  logic [INST_ID_BITS-1:0] complete_inst_id [FU_COUNT],
    output logic [INST_ID_BITS-1:0] new_inst_id,
    output logic                    rob_full,
    output logic                    rob_empty,
    output logic                    commit_valid,
    output logic [INST_ID_BITS-1:0] commit_inst_id,
    output logic                    free_valid       [MAX_OPERANDS],
    output logic [PRN_BITS-1:0]     free_prns        [MAX_OPERANDS]
);

    localparam logic [INST_ID_BITS:0] FULL_COUNT = (INST_ID_BITS + 1)'(DEPTH);

    rob_entry_t                rob_mem [DEPTH];
    logic [INST_ID_BITS-1:0]   head;
    logic [INST_ID_BITS-1:0]   tail;
    logic [INST_ID_BITS:0]     count;
    rob_entry_t                head_entry;
    logic                      alloc_accept;
    logic                      commit_fire;

    // Status comes only from registered count, so rename sees no input-to-output path.
    assign new_inst_id  = tail;
    assign rob_full     = (count == FULL_COUNT);
    assign rob_empty    = (count == '0);
    assign head_entry   = rob_mem[head];
    assign alloc_accept = alloc_valid & ~rob_full & ~flush;
    assign commit_fire  = head_entry.valid & head_entry.done & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_mem[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_mem[i].valid <= 1'b0;
                rob_mem[i].done  <= 1'b0;
            end
        end else begin
            if (commit_fire) begin
                rob_mem[head].valid <= 1'b0;
                rob_mem[head].done  <= 1'b0;
            end
            if (alloc_accept) begin
                rob_mem[tail].valid <= 1'b1;
                rob_mem[tail].done  <= 1'b0;
                for (int j = 0; j < MAX_OPERANDS; j++) begin
                    rob_mem[tail].old_valid[j] <= alloc_old_valid[j];
                    rob_mem[tail].old_prn[j]   <= alloc_old_prn[j];
                    rob_mem[tail].old_arn[j]   <= alloc_old_arn[j];
                end
            end
            // Validity is judged on the pre-edge entry, so a slot being
            // allocated this cycle cannot be marked done by a stale completion.
            for (int k = 0; k < FU_COUNT; k++) begin
                if (complete_valid[k] && rob_mem[complete_inst_id[k]].valid) begin
                    rob_mem[complete_inst_id[k]].done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_accept) tail <= tail + 1'b1;
            if (commit_fire)  head <= head + 1'b1;
            case ({alloc_accept, commit_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid   <= 1'b0;
            commit_inst_id <= '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                free_valid[i] <= 1'b0;
                free_prns[i]  <= '0;
            end
        end else begin
            commit_valid   <= commit_fire;
            commit_inst_id <= commit_fire ? head : '0;
            for (int i = 0; i < MAX_OPERANDS; i++) begin
                free_valid[i] <= commit_fire & head_entry.old_valid[i];
                free_prns[i]  <= (commit_fire && head_entry.old_valid[i])
                                 ? head_entry.old_prn[i] : '0;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a queue-based model.
module tb_reorder_buffer;

    localparam int NOPS = 3;
    localparam int NFU  = 4;
    localparam int NENT = 64;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       alloc_valid;
    logic       alloc_old_valid  [NOPS];
    logic [5:0] alloc_old_prn    [NOPS];
    logic [5:0] alloc_old_arn    [NOPS];
    logic       complete_valid   [NFU];
    logic [5:0] complete_inst_id [NFU];
    logic [5:0] new_inst_id;
    logic       rob_full;
    logic       rob_empty;
    logic       commit_valid;
    logic [5:0] commit_inst_id;
    logic       free_valid       [NOPS];
    logic [5:0] free_prns        [NOPS];

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .alloc_valid      (alloc_valid),
        .alloc_old_valid  (alloc_old_valid),
        .alloc_old_prn    (alloc_old_prn),
        .alloc_old_arn    (alloc_old_arn),
        .complete_valid   (complete_valid),
        .complete_inst_id (complete_inst_id),
        .new_inst_id      (new_inst_id),
        .rob_full         (rob_full),
        .rob_empty        (rob_empty),
        .commit_valid     (commit_valid),
        .commit_inst_id   (commit_inst_id),
        .free_valid       (free_valid),
        .free_prns        (free_prns)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int       id;
        bit [2:0] ov;
        int       prn [NOPS];
    } rec_t;

    rec_t q[$];
    bit   mdone [NENT];
    int   next_id;
    int   exp_cv;
    int   exp_cid;
    int   exp_fv [NOPS];
    int   exp_fp [NOPS];
    int   n_checks;
    int   n_errors;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_live(input int id);
        foreach (q[j]) if (q[j].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        q.delete();
        next_id = 0;
        exp_cv  = 0;
        exp_cid = 0;
        for (int i = 0; i < NENT; i++) mdone[i] = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            exp_fv[i] = 0;
            exp_fp[i] = 0;
        end
    endtask

    task automatic set_idle();
        flush       = 1'b0;
        alloc_valid = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            alloc_old_valid[i] = 1'b0;
            alloc_old_prn[i]   = '0;
            alloc_old_arn[i]   = '0;
        end
        for (int k = 0; k < NFU; k++) begin
            complete_valid[k]   = 1'b0;
            complete_inst_id[k] = '0;
        end
    endtask

    task automatic set_alloc_random();
        alloc_valid = 1'b1;
        for (int i = 0; i < NOPS; i++) begin
            alloc_old_valid[i] = 1'($urandom_range(0, 1));
            alloc_old_prn[i]   = 6'($urandom_range(0, 63));
            alloc_old_arn[i]   = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic set_complete(input int port, input int id);
        complete_valid[port]   = 1'b1;
        complete_inst_id[port] = 6'(id);
    endtask

    task automatic compare_all();
        check_val("new_inst_id", int'(new_inst_id), next_id);
        check_val("rob_full", int'(rob_full), int'(q.size() == NENT));
        check_val("rob_empty", int'(rob_empty), int'(q.size() == 0));
        check_val("commit_valid", int'(commit_valid), exp_cv);
        check_val("commit_inst_id", int'(commit_inst_id), exp_cid);
        for (int i = 0; i < NOPS; i++) begin
            check_val($sformatf("free_valid[%0d]", i), int'(free_valid[i]), exp_fv[i]);
            check_val($sformatf("free_prns[%0d]", i), int'(free_prns[i]), exp_fp[i]);
        end
    endtask

    // Model acts on the inputs present before the edge, then the DUT is compared after it.
    task automatic step();
        bit   full_now;
        bit   do_commit;
        rec_t c;
        rec_t r;
        full_now  = (q.size() == NENT);
        do_commit = 1'b0;
        if (flush) begin
            model_clear();
        end else begin
            if (q.size() > 0 && mdone[q[0].id]) begin
                do_commit = 1'b1;
                c = q[0];
            end
            for (int k = 0; k < NFU; k++) begin
                if (complete_valid[k] && is_live(int'(complete_inst_id[k])))
                    mdone[int'(complete_inst_id[k])] = 1'b1;
            end
            if (do_commit) void'(q.pop_front());
            if (alloc_valid && !full_now) begin
                r.id = next_id;
                for (int i = 0; i < NOPS; i++) begin
                    r.ov[i]  = alloc_old_valid[i];
                    r.prn[i] = int'(alloc_old_prn[i]);
                end
                mdone[next_id] = 1'b0;
                q.push_back(r);
                next_id = (next_id + 1) % NENT;
            end
            exp_cv  = int'(do_commit);
            exp_cid = do_commit ? c.id : 0;
            for (int i = 0; i < NOPS; i++) begin
                exp_fv[i] = (do_commit && c.ov[i]) ? 1 : 0;
                exp_fp[i] = (do_commit && c.ov[i]) ? c.prn[i] : 0;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic flush_step();
        set_idle();
        flush = 1'b1;
        step();
        set_idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_clear();
        set_idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare_all();

        // Single instruction round trip with one meaningful old mapping.
        alloc_valid        = 1'b1;
        alloc_old_valid[0] = 1'b1;
        alloc_old_prn[0]   = 6'd17;
        step();
        set_idle();
        set_complete(0, 0);
        step();
        set_idle();
        step();
        check_val("rt_commit_valid", int'(commit_valid), 1);
        check_val("rt_free_prn0", int'(free_prns[0]), 17);
        check_val("rt_free_valid1", int'(free_valid[1]), 0);
        step();
        check_val("rt_empty_after", int'(rob_empty), 1);

        // Out-of-order completion retires in program order.
        flush_step();
        for (int n = 0; n < 3; n++) begin
            set_alloc_random();
            step();
        end
        set_idle();
        for (int id = 2; id >= 0; id--) begin
            set_complete(0, id);
            step();
            set_idle();
            if (id != 0) check_val("ooo_no_commit", int'(commit_valid), 0);
        end
        for (int id = 0; id < 3; id++) begin
            step();
            check_val("ooo_commit_id", int'(commit_inst_id), id);
        end

        // Fill to full, drop overflow, and reject allocation in the commit cycle.
        flush_step();
        for (int n = 0; n < NENT; n++) begin
            set_alloc_random();
            step();
        end
        check_val("full_after_64", int'(rob_full), 1);
        set_alloc_random();
        step();
        check_val("overflow_dropped_id", int'(new_inst_id), 0);
        set_idle();
        set_complete(1, 0);
        step();
        set_alloc_random();
        step();
        check_val("full_commit_valid", int'(commit_valid), 1);
        check_val("full_cleared", int'(rob_full), 0);
        check_val("full_reject_id", int'(new_inst_id), 0);
        step();
        check_val("realloc_took_id0", int'(new_inst_id), 1);
        set_idle();

        // Four completions in one cycle retire on four consecutive cycles.
        flush_step();
        for (int n = 0; n < 4; n++) begin
            set_alloc_random();
            step();
        end
        set_idle();
        for (int k = 0; k < NFU; k++) set_complete(k, k);
        step();
        set_idle();
        for (int id = 0; id < 4; id++) begin
            step();
            check_val("multi_commit_id", int'(commit_inst_id), id);
        end

        // Steady allocate-and-complete stream across the 63 -> 0 wrap.
        flush_step();
        for (int n = 0; n < 200; n++) begin
            set_idle();
            set_alloc_random();
            if (q.size() > 0) set_complete(n % NFU, q[q.size() - 1].id);
            step();
        end
        set_idle();
        repeat (4) step();

        // Flush with live entries, one of them done.
        flush_step();
        for (int n = 0; n < 5; n++) begin
            set_alloc_random();
            step();
        end
        set_idle();
        set_complete(2, 2);
        step();
        set_idle();
        flush_step();
        check_val("flush_no_commit", int'(commit_valid), 0);
        check_val("flush_empty", int'(rob_empty), 1);
        check_val("flush_new_id", int'(new_inst_id), 0);

        // Mid-operation reset: outputs clear asynchronously, no frees afterwards.
        for (int n = 0; n < 6; n++) begin
            set_alloc_random();
            step();
        end
        set_idle();
        set_complete(0, 0);
        set_complete(1, 1);
        step();
        set_idle();
        step();
        #2 rst = 1'b1;
        #1;
        model_clear();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #2 rst = 1'b0;
        repeat (3) step();

        // Randomized traffic alternating fill-heavy and drain-heavy phases.
        for (int n = 0; n < 3000; n++) begin
            int fill_phase;
            fill_phase = ((n / 400) % 2 == 0) ? 1 : 0;
            set_idle();
            if ($urandom_range(0, 99) < (fill_phase ? 90 : 40)) set_alloc_random();
            for (int k = 0; k < NFU; k++) begin
                if ($urandom_range(0, 99) < (fill_phase ? 10 : 50)) begin
                    if (q.size() > 0 && $urandom_range(0, 3) != 0)
                        set_complete(k, q[$urandom_range(0, q.size() - 1)].id);
                    else
                        set_complete(k, int'($urandom_range(0, NENT - 1)));
                end
            end
            if ($urandom_range(0, 299) == 0) flush = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters SHALL be: MAX_OPERANDS, default 3, destination slots per instruction; PRN_BITS, default 6, physical register index width; ARN_BITS, default 6, architectural register index width; INST_ID_BITS, default 6, entry index width (DEPTH = 2**INST_ID_BITS = 64); FU_COUNT, default 4, completion ports.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries.
- alloc_valid  in  1  rename presents a renamed instruction.
- alloc_old_valid[MAX_OPERANDS]  in  1  old mapping slot is meaningful.
- alloc_old_prn[MAX_OPERANDS]  in  PRN_BITS  PRN to free at commit.
- alloc_old_arn[MAX_OPERANDS]  in  ARN_BITS  ARN of the overwritten mapping.
- complete_valid[FU_COUNT]  in  1  FU finished an instruction.
- complete_inst_id[FU_COUNT]  in  INST_ID_BITS  id of the finished instruction.
- new_inst_id  out  INST_ID_BITS  id the next allocation receives (tail).
- rob_full  out  1  count == DEPTH; rename SHALL stall.
- rob_empty  out  1  count == 0.
- commit_valid  out  1  one instruction retired.
- commit_inst_id  out  INST_ID_BITS  id retired.
- free_valid[MAX_OPERANDS]  out  1  PRN returned to the free list.
- free_prns[MAX_OPERANDS]  out  PRN_BITS  PRN returned.

Function
REQ-003 Each entry SHALL hold valid, done, and MAX_OPERANDS (old_valid, old_prn, old_arn) triples; head, tail and count (INST_ID_BITS+1 bits) SHALL be registers.
REQ-004 new_inst_id SHALL equal tail; rob_full and rob_empty SHALL be decoded from registered count, with no combinational path from any input.
REQ-005 An allocation SHALL be accepted iff alloc_valid=1, rob_full=0 and flush=0; the entry at tail gets valid=1, done=0 and the old triples; tail increments modulo DEPTH.
REQ-006 alloc_valid while rob_full=1 SHALL be dropped with no state change.
REQ-007 complete_valid[k] SHALL set done of entry complete_inst_id[k] only if that entry is valid at the start of the cycle; completions to invalid entries SHALL be ignored.
REQ-008 Several completion ports naming the same or different ids in one cycle SHALL all take effect.
REQ-009 Commit SHALL occur when the registered head entry has valid=1 and done=1 and flush=0, at most one per cycle, in program order.
REQ-010 On commit: head entry valid clears, head increments modulo DEPTH, and at the same edge commit_valid=1, commit_inst_id=old head, free_valid[i]=old_valid[i], free_prns[i]=old_prn[i] are registered.
REQ-011 Commit outputs SHALL pulse for exactly one cycle per commit and be 0 otherwise; free_prns SHALL hold 0 when free_valid is 0.
REQ-012 Minimum latency: completion at edge N makes the head eligible at N; commit outputs are visible after edge N+1.
REQ-013 Simultaneous accepted allocation and commit SHALL leave count unchanged; allocation alone increments it; commit alone decrements it.
REQ-014 When full with a commit pending in the same cycle, the allocation SHALL still be rejected (rob_full is registered).
REQ-015 Pointers SHALL wrap 63 -> 0 with no gap or bubble.
REQ-016 flush=1 SHALL take priority over allocation, completion and commit. In the next cycle, all valid and done bits are cleared, head=tail=0, count=0, and commit/free outputs are 0. Flushed entries issue no frees.

Reset
REQ-017 rst=1 SHALL asynchronously clear head, tail, count and every valid/done bit, and drive commit_valid=0, commit_inst_id=0, every free_valid=0 and every free_prns=0. After reset, rob_empty=1, rob_full=0 and new_inst_id=0.
REQ-018 Reset asserted mid-operation SHALL discard all entries and generate no frees; operation resumes on the first edge after deassertion.

Structure
REQ-019 A shared package foxtrot_pkg SHALL define the rob_entry_t struct and the DEPTH constant derived from INST_ID_BITS.
REQ-020 Entry storage and pointer logic SHALL live in this module; no sub-module is required.

Verification
REQ-021 Reset, then one allocation with old_valid={1,0,0} and old_prn[0]=17, then complete id 0 -> commit_valid=1, commit_inst_id=0, free_valid[0]=1 with free_prns[0]=17, free_valid[1..2]=0, one cycle later rob_empty=1.
REQ-022 Allocate ids 0,1,2, then complete 2, then 1, then 0 -> no commit until id 0 is done, then commits 0,1,2 on consecutive cycles.
REQ-023 64 allocations with no completion -> rob_full=1; a 65th alloc_valid is dropped and new_inst_id stays 0; complete 0 -> one commit, rob_full=0, the next allocation receives id 0.
REQ-024 Steady alloc+commit for 200 cycles -> count constant, ids wrap 63 -> 0, every old_prn freed exactly once in order.
REQ-025 Same-cycle completions on ports 0..3 to ids 0..3 -> four commits on four consecutive cycles.
REQ-026 Flush with 5 entries live, one of them done -> no commit or free, rob_empty=1, new_inst_id=0 next cycle.
